gate_input_conditioner: RTL and testbench
=========================================

// Module: gate_input_conditioner
// PURPOSE
//   Upstream conditioning stage for the two-input logic-gate blocks.
//   Takes WIDTH raw, asynchronous switch/button levels and synchronises each to clk.
//   Debounces each channel and drives clean levels straight into the gate inputs (a, b).
//   Also emits per-channel one-cycle edge pulses for downstream counters and LEDs.
// PARAMETERS
//   WIDTH            2   number of independent input channels (>=1)
//   DEBOUNCE_CYCLES  16  consecutive disagreeing synced samples needed to accept a new level (>=1)
//   CNT_W            $clog2(DEBOUNCE_CYCLES+1), localparam: debounce counter width
// PORTS
//   clk         in   1      single system clock; all state is on its rising edge
//   rst_n       in   1      asynchronous, active-low reset
//   raw_in      in   WIDTH  unsynchronised input levels; may glitch or bounce
//   clean_out   out  WIDTH  debounced levels; bit0 -> gate input a, bit1 -> gate input b
//   rise_pulse  out  WIDTH  1-cycle pulse in the cycle clean_out[i] goes 0->1
//   fall_pulse  out  WIDTH  1-cycle pulse in the cycle clean_out[i] goes 1->0
//   settled     out  1      1 when no channel has a debounce in progress
// BEHAVIOUR
//   Reset: sync1, sync2, clean_out, counters, rise_pulse and fall_pulse all clear to 0.
//     settled reads 1 during reset. Any debounce in progress when reset asserts is discarded.
//   Per channel i, two-flop synchroniser: sync1 <= raw_in[i]; sync2 <= sync1. No other logic
//     touches sync1.
//   Per-channel FSM, two states:
//     STABLE: sync2 == clean, cnt == 0. If sync2 != clean, go to PENDING with cnt <= 1.
//       If DEBOUNCE_CYCLES == 1, toggle clean on that same edge instead and stay in STABLE.
//     PENDING: if sync2 == clean, abort: cnt <= 0 and go to STABLE (glitch rejected).
//       Else if cnt == DEBOUNCE_CYCLES-1: clean <= ~clean, cnt <= 0, go to STABLE.
//       Else cnt <= cnt+1.
//   Latency: raw_in held stable from edge k => clean_out changes after edge k+2+DEBOUNCE_CYCLES.
//     Output is registered; there is no combinational path from raw_in.
//   Pulses are registered and aligned with the clean_out change:
//     rise_pulse[i] is high exactly in the first cycle clean_out[i]==1 after a 0.
//     fall_pulse[i] is the mirror. rise_pulse[i] and fall_pulse[i] are never high together.
//   settled = ~|(per-channel PENDING flags). It is combinational from registered state.
//   Channels are fully independent; simultaneous transitions on several channels are legal.
//   raw_in high when reset releases: treated as a normal 0->1 change.
//     clean_out rises after 2+DEBOUNCE_CYCLES edges and a rise_pulse is produced.
//   Counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
//   Elaboration-time check: DEBOUNCE_CYCLES < 1 or WIDTH < 1 is a fatal error.
// STRUCTURE
//   Shared include gate_defs.vh:
//     `define GATE_DEBOUNCE_DEFAULT 16
//     state encodings DB_STABLE=1'b0, DB_PENDING=1'b1
//   Sub-module debounce_channel (clk, rst_n, raw, clean, rise, fall, pending).
//     Holds the synchroniser, counter and FSM for one bit.
//     Top level is a generate loop of WIDTH instances plus the settled reduction.
// TESTING (bench uses DEBOUNCE_CYCLES=4, WIDTH=2)
//   Reset, raw_in=2'b00 held 20 cycles:
//     clean_out=00, no pulses, settled=1 throughout.
//   raw_in[0] 0->1 before edge k, then held:
//     clean_out[0]=1 after edge k+6; rise_pulse[0]=1 for exactly that one cycle;
//     settled=0 after edges k+3..k+5.
//   Bounce: raw_in[1] 1 for 3 cycles, then 0 for 1, then 1 held:
//     first burst rejected (no change, no pulse); clean_out[1] rises 6 edges after the final 0->1.
//   Both channels 1->0 at the same edge:
//     both clean bits fall on the same edge, fall_pulse=2'b11 for one cycle, rise_pulse=00.
//   Assert rst_n=0 while channel 0 is PENDING (cnt=2):
//     outputs clear immediately; after release with raw_in[0]=1, clean_out[0] rises 6 edges later.
//   Rebuild with DEBOUNCE_CYCLES=1:
//     a step on raw_in reaches clean_out 3 edges after it was applied; a 1-cycle glitch still
//     passes after 3 edges, since sync2 already disagrees.

Source files
------------

// File: rtl/gate_input_conditioner_pkg.sv
// Shared types and constants for the gate input conditioner.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package gate_input_conditioner_pkg;

    // Default debounce window, in synchronised clock samples.
    localparam int GATE_DEBOUNCE_DEFAULT = 16;

    // Per-channel debounce state.
    typedef enum logic {
        DB_STABLE  = 1'b0,
        DB_PENDING = 1'b1
    } db_state_e;

    // Counter width able to hold 0..debounce_cycles.
    function automatic int cnt_width(input int debounce_cycles);
        return $clog2(debounce_cycles + 1);
    endfunction

endpackage

// File: rtl/gate_input_conditioner_debounce_channel.sv
// One-bit synchroniser + debouncer with registered edge pulses and a pending flag.
// Latency: raw held from edge k reaches clean after edge k+2+DEBOUNCE_CYCLES.
// Backpressure: none; raw is sampled every cycle and outputs are free-running.
module debounce_channel
    import gate_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = GATE_DEBOUNCE_DEFAULT,
    parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic pending
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q;
    logic             sync2_q;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clean_q, clean_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // Two-flop synchroniser; sync1 feeds nothing but sync2 to limit metastability exposure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce state, counter, clean level and edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DB_STABLE;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Next-state: count consecutive disagreeing samples, abort on any agreeing one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        case (state_q)
            DB_STABLE: begin
                if (sync2_q != clean_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        // A single disagreeing sample is already the full window.
                        clean_d = ~clean_q;
                    end else begin
                        state_d = DB_PENDING;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            DB_PENDING: begin
                if (sync2_q == clean_q) begin
                    state_d = DB_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    clean_d = ~clean_q;
                    cnt_d   = '0;
                    state_d = DB_STABLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = DB_STABLE;
                cnt_d   = '0;
            end
        endcase
        // Pulses are registered alongside clean so they line up with its change.
        rise_d = clean_d & ~clean_q;
        fall_d = ~clean_d & clean_q;
    end

    assign clean   = clean_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign pending = (state_q == DB_PENDING);

endmodule

// File: rtl/gate_input_conditioner.sv
// Synchronises and debounces WIDTH raw switch levels into clean gate inputs plus edge pulses.
// Latency: 2 sync stages + DEBOUNCE_CYCLES samples; all outputs registered except settled.
// Backpressure: none; every channel samples every cycle independently.
module gate_input_conditioner
    import gate_input_conditioner_pkg::*;
#(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = GATE_DEBOUNCE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             settled
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

    logic [WIDTH-1:0] pending_w;

    // Reject configurations that cannot debounce anything.
    if (DEBOUNCE_CYCLES < 1 || WIDTH < 1) begin : g_bad_cfg
        $fatal(1, "gate_input_conditioner: DEBOUNCE_CYCLES and WIDTH must both be >= 1");
    end

    // One fully independent debouncer per channel.
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw    (raw_in[i]),
            .clean  (clean_out[i]),
            .rise   (rise_pulse[i]),
            .fall   (fall_pulse[i]),
            .pending(pending_w[i])
        );
    end

    // Quiet when no channel is mid-debounce.
    assign settled = ~|pending_w;

endmodule

// File: tb/tb_gate_input_conditioner.sv
// Bench: two builds (DEBOUNCE_CYCLES=4 and =1) driven by the same raw inputs.
// Latency: n/a.
// Backpressure: n/a.
module tb_gate_input_conditioner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] raw_in;

    logic [1:0] clean_a, rise_a, fall_a;
    logic       settled_a;
    logic [1:0] clean_b, rise_b, fall_b;
    logic       settled_b;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    gate_input_conditioner #(.WIDTH(2), .DEBOUNCE_CYCLES(4)) u_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw_in    (raw_in),
        .clean_out (clean_a),
        .rise_pulse(rise_a),
        .fall_pulse(fall_a),
        .settled   (settled_a)
    );

    gate_input_conditioner #(.WIDTH(2), .DEBOUNCE_CYCLES(1)) u_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw_in    (raw_in),
        .clean_out (clean_b),
        .rise_pulse(rise_b),
        .fall_pulse(fall_b),
        .settled   (settled_b)
    );

    // Reference model: per build and channel, a 2-deep sample delay line and a run
    // length of consecutive delayed samples that disagree with the clean level.
    int         dcyc [2] = '{4, 1};
    logic [1:0] m_s1 [2];
    logic [1:0] m_s2 [2];
    logic [1:0] m_clean [2];
    logic [1:0] m_rise [2];
    logic [1:0] m_fall [2];
    int         m_run [2][2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_s1[d] = '0; m_s2[d] = '0; m_clean[d] = '0; m_rise[d] = '0; m_fall[d] = '0;
            for (int c = 0; c < 2; c++) m_run[d][c] = 0;
        end
    endtask

    task automatic model_edge(input logic [1:0] raw);
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 2; c++) begin
                logic oc;
                oc = m_clean[d][c];
                if (m_s2[d][c] != oc) begin
                    m_run[d][c] = m_run[d][c] + 1;
                    if (m_run[d][c] >= dcyc[d]) begin
                        m_clean[d][c] = ~oc;
                        m_run[d][c]   = 0;
                    end
                end else begin
                    m_run[d][c] = 0;
                end
                m_rise[d][c] = m_clean[d][c] & ~oc;
                m_fall[d][c] = ~m_clean[d][c] & oc;
            end
            m_s2[d] = m_s1[d];
            m_s1[d] = raw;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("clean_a",   int'(clean_a),   int'(m_clean[0]));
        chk("rise_a",    int'(rise_a),    int'(m_rise[0]));
        chk("fall_a",    int'(fall_a),    int'(m_fall[0]));
        chk("settled_a", int'(settled_a), int'(m_run[0][0] == 0 && m_run[0][1] == 0));
        chk("clean_b",   int'(clean_b),   int'(m_clean[1]));
        chk("rise_b",    int'(rise_b),    int'(m_rise[1]));
        chk("fall_b",    int'(fall_b),    int'(m_fall[1]));
        chk("settled_b", int'(settled_b), int'(m_run[1][0] == 0 && m_run[1][1] == 0));
    endtask

    // One clock edge: advance the model (unless in reset), then check 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge(raw_in);
        #1;
        check_all();
    endtask

    // Tick n edges and report the first edge index (1-based) at which each build's
    // clean_out[ch] reads 1; 99 if it never did within the budget.
    task automatic run_lat(input int ch, input int n, output int la, output int lb);
        la = 99; lb = 99;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (la == 99 && clean_a[ch]) la = i;
            if (lb == 99 && clean_b[ch]) lb = i;
        end
    endtask

    initial begin
        int la, lb, nf;
        rst_n  = 1'b0;
        raw_in = 2'b00;
        model_reset();
        #1;
        check_all();
        repeat (2) tick();
        rst_n = 1'b1;

        // Idle with inputs low.
        repeat (20) tick();

        // Clean step on channel 0.
        raw_in = 2'b01;
        run_lat(0, 10, la, lb);
        chk("step_lat_d4", la, 6);
        chk("step_lat_d1", lb, 3);

        // Bounce on channel 1: 3 high, 1 low, then held high.
        raw_in[1] = 1'b1;
        repeat (3) tick();
        raw_in[1] = 1'b0;
        tick();
        chk("bounce_rejected", int'(clean_a[1]), 0);
        raw_in[1] = 1'b1;
        run_lat(1, 10, la, lb);
        chk("bounce_lat_d4", la, 6);

        // Both channels fall together.
        repeat (4) tick();
        raw_in = 2'b00;
        nf = 99;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (nf == 99 && clean_a == 2'b00) begin
                nf = i;
                chk("both_fall_pulse", int'(fall_a), 3);
                chk("both_fall_rise", int'(rise_a), 0);
            end
        end
        chk("both_fall_lat", nf, 6);

        // Reset while channel 0 is mid-debounce, released with input high.
        raw_in = 2'b01;
        repeat (4) tick();
        chk("pre_reset_pending", int'(settled_a), 0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) tick();
        rst_n = 1'b1;
        run_lat(0, 10, la, lb);
        chk("post_reset_lat_d4", la, 6);
        chk("post_reset_lat_d1", lb, 3);

        // Single-cycle glitch on channel 1: rejected by D=4, passed by D=1.
        repeat (4) tick();
        raw_in = 2'b11;
        tick();
        raw_in = 2'b01;
        run_lat(1, 8, la, lb);
        chk("glitch_d4", la, 99);
        chk("glitch_d1", lb, 2);
        repeat (8) tick();

        // Randomised activity: occasional toggles of random channels.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) raw_in = raw_in ^ 2'($urandom_range(1, 3));
            tick();
        end
        raw_in = 2'b00;
        repeat (12) tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
